// File: rtl/clock_div_ctrl_if.sv
// Control/status bundle between rate-request logic and the divider controller.
// period_cnt is present only when CLKDIV_PERIOD_CNT_EN is defined.
interface clock_div_ctrl_if;
    logic       run;
    logic [1:0] sel;
    logic       req;
    logic       ack;
    logic       busy;
    logic [1:0] cur_sel;
    logic       clock_out;
    logic       tick;
`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0] period_cnt;

    modport master (output run, sel, req,
                    input  ack, busy, cur_sel, clock_out, tick, period_cnt);
    modport slave  (input  run, sel, req,
                    output ack, busy, cur_sel, clock_out, tick, period_cnt);
`else
    modport master (output run, sel, req,
                    input  ack, busy, cur_sel, clock_out, tick);
    modport slave  (input  run, sel, req,
                    output ack, busy, cur_sel, clock_out, tick);
`endif
endinterface

// File: rtl/clock_div_ctrl.sv
// Purpose: programmable square-wave divider, 4 presets, glitch-free start/stop/switch.
// Latency: all outputs registered; rate changes and stops land on the next period boundary.
// Backpressure: none; req while busy is dropped. Optional period_cnt via CLKDIV_PERIOD_CNT_EN.
module clock_div_ctrl #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned DIV0  = 100000000,
    parameter int unsigned DIV1  = 7692307,
    parameter int unsigned DIV2  = 1000000,
    parameter int unsigned DIV3  = 100000
) (
    input  logic                  clock_in,
    input  logic                  reset_n,
    clock_div_ctrl_if.slave       bus
);
    // Divisors below 2 cannot form a high and a low phase, so they are clamped.
    localparam int unsigned C0 = (DIV0 < 2) ? 2 : DIV0;
    localparam int unsigned C1 = (DIV1 < 2) ? 2 : DIV1;
    localparam int unsigned C2 = (DIV2 < 2) ? 2 : DIV2;
    localparam int unsigned C3 = (DIV3 < 2) ? 2 : DIV3;
    localparam logic [WIDTH-1:0] P0  = C0[WIDTH-1:0];
    localparam logic [WIDTH-1:0] P1  = C1[WIDTH-1:0];
    localparam logic [WIDTH-1:0] P2  = C2[WIDTH-1:0];
    localparam logic [WIDTH-1:0] P3  = C3[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, SWITCH} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]       cur_sel_q, cur_sel_d;
    logic [1:0]       pend_sel_q, pend_sel_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] div_eff;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] cnt_inc;
    logic             at_end;

    always_comb begin
        case (cur_sel_q)
            2'd0:    div_eff = P0;
            2'd1:    div_eff = P1;
            2'd2:    div_eff = P2;
            default: div_eff = P3;
        endcase
    end

    assign half    = div_eff >> 1;
    assign cnt_inc = cnt_q + ONE;
    assign at_end  = (cnt_q == div_eff - ONE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_sel_d  = cur_sel_q;
        pend_sel_d = pend_sel_q;
        clk_out_d  = clk_out_q;
        tick_d     = 1'b0;
        ack_d      = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                if (bus.req) begin
                    cur_sel_d = bus.sel;
                    ack_d     = 1'b1;
                end
                if (bus.run) begin
                    state_d   = RUN;
                    clk_out_d = 1'b1;
                end
            end
            RUN: begin
                if (at_end) begin
                    cnt_d = '0;
                    if (bus.run) begin
                        tick_d    = 1'b1;
                        clk_out_d = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        clk_out_d = 1'b0;
                    end
                end else begin
                    cnt_d     = cnt_inc;
                    clk_out_d = (cnt_inc < half);
                end
                // A request arriving as the output stops has no period to wait for.
                if (bus.req) begin
                    if (at_end && !bus.run) begin
                        cur_sel_d = bus.sel;
                        ack_d     = 1'b1;
                    end else begin
                        pend_sel_d = bus.sel;
                        busy_d     = 1'b1;
                        state_d    = SWITCH;
                    end
                end
            end
            SWITCH: begin
                if (at_end) begin
                    cnt_d     = '0;
                    cur_sel_d = pend_sel_q;
                    busy_d    = 1'b0;
                    ack_d     = 1'b1;
                    if (bus.run) begin
                        state_d   = RUN;
                        tick_d    = 1'b1;
                        clk_out_d = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        clk_out_d = 1'b0;
                    end
                end else begin
                    cnt_d     = cnt_inc;
                    clk_out_d = (cnt_inc < half);
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                clk_out_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_sel_q  <= 2'd0;
            pend_sel_q <= 2'd0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_sel_q  <= cur_sel_d;
            pend_sel_q <= pend_sel_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.busy      = busy_q;
    assign bus.cur_sel   = cur_sel_q;
    assign bus.clock_out = clk_out_q;
    assign bus.tick      = tick_q;

`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0] pcnt_q, pcnt_d;

    always_comb begin
        pcnt_d = pcnt_q;
        if (ack_d)
            pcnt_d = 16'd0;
        else if (tick_d)
            pcnt_d = pcnt_q + 16'd1;
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n)
            pcnt_q <= 16'd0;
        else
            pcnt_q <= pcnt_d;
    end

    assign bus.period_cnt = pcnt_q;
`endif
endmodule

// File: tb/tb_clock_div_ctrl.sv
// Directed bench for clock_div_ctrl with small presets (4, 6, 10, 3) and a clamp instance (preset 1).
module tb_clock_div_ctrl;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    clock_div_ctrl_if ifm ();
    clock_div_ctrl_if ifc ();

    clock_div_ctrl #(.WIDTH(28), .DIV0(4), .DIV1(6), .DIV2(10), .DIV3(3)) dut (
        .clock_in (clk),
        .reset_n  (reset_n),
        .bus      (ifm)
    );

    clock_div_ctrl #(.WIDTH(28), .DIV0(1), .DIV1(6), .DIV2(10), .DIV3(3)) dut_c (
        .clock_in (clk),
        .reset_n  (reset_n),
        .bus      (ifc)
    );

    // Expected bundle layout: {clock_out, tick, ack, busy, cur_sel[1:0]}
    typedef struct {
        logic       run;
        logic [1:0] sel;
        logic       req;
        logic [5:0] exp;
    } vec_t;

    vec_t vq[$];
    int   ntests = 0;
    int   nfail  = 0;

    task automatic add(input int n, input logic r, input logic [1:0] s, input logic q,
                       input logic co, input logic tk, input logic ak, input logic bz,
                       input logic [1:0] cs);
        for (int k = 0; k < n; k++) begin
            vec_t v;
            v.run = r;
            v.sel = s;
            v.req = q;
            v.exp = {co, tk, ak, bz, cs};
            vq.push_back(v);
        end
    endtask

    task automatic check(input string name, input int idx, input logic [5:0] act, input logic [5:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s[%0d]: got co=%b tick=%b ack=%b busy=%b cur_sel=%0d, want co=%b tick=%b ack=%b busy=%b cur_sel=%0d",
                     name, idx, act[5], act[4], act[3], act[2], act[1:0],
                     exp[5], exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    function automatic logic [5:0] snap_m();
        return {ifm.clock_out, ifm.tick, ifm.ack, ifm.busy, ifm.cur_sel};
    endfunction

    function automatic logic [5:0] snap_c();
        return {ifc.clock_out, ifc.tick, ifc.ack, ifc.busy, ifc.cur_sel};
    endfunction

    initial begin
        logic [5:0] cexp [6];

        ifm.run = 1'b0; ifm.sel = 2'd0; ifm.req = 1'b0;
        ifc.run = 1'b0; ifc.sel = 2'd0; ifc.req = 1'b0;

        //   n run sel req  co tk ak bz cs
        add(2, 1, 0, 0,   1, 0, 0, 0, 0);   // start at preset 0 (D=4)
        add(2, 1, 0, 0,   0, 0, 0, 0, 0);
        add(1, 1, 0, 0,   1, 1, 0, 0, 0);   // first tick
        add(1, 1, 0, 0,   1, 0, 0, 0, 0);   // counter = 1
        add(1, 1, 2, 1,   0, 0, 0, 1, 0);   // request preset 2
        add(1, 1, 1, 1,   0, 0, 0, 1, 0);   // request while busy: ignored
        add(1, 1, 0, 0,   1, 1, 1, 0, 2);   // ack + tick together
        add(4, 1, 0, 0,   1, 0, 0, 0, 2);   // D=10: 5 high
        add(5, 1, 0, 0,   0, 0, 0, 0, 2);   //       5 low
        add(1, 1, 0, 0,   1, 1, 0, 0, 2);
        add(1, 1, 3, 1,   1, 0, 0, 1, 2);   // request preset 3
        add(3, 1, 0, 0,   1, 0, 0, 1, 2);
        add(5, 1, 0, 0,   0, 0, 0, 1, 2);
        add(1, 1, 0, 0,   1, 1, 1, 0, 3);   // D=3: 1 high / 2 low
        add(2, 1, 0, 0,   0, 0, 0, 0, 3);
        add(1, 1, 0, 0,   1, 1, 0, 0, 3);
        add(2, 1, 0, 0,   0, 0, 0, 0, 3);
        add(1, 1, 0, 0,   1, 1, 0, 0, 3);
        add(1, 1, 1, 1,   0, 0, 0, 1, 3);   // request preset 1
        add(1, 1, 0, 0,   0, 0, 0, 1, 3);
        add(1, 1, 0, 0,   1, 1, 1, 0, 1);   // D=6
        add(2, 1, 0, 0,   1, 0, 0, 0, 1);   // counter = 2
        add(5, 0, 0, 0,   0, 0, 0, 0, 1);   // stop: finish period, then idle low
        add(1, 0, 3, 1,   0, 0, 1, 0, 3);   // idle request acks at once
        add(1, 0, 0, 0,   0, 0, 0, 0, 3);
        add(1, 1, 2, 1,   1, 0, 1, 0, 2);   // idle req + run: new preset first period
        add(4, 1, 0, 0,   1, 0, 0, 0, 2);
        add(5, 1, 0, 0,   0, 0, 0, 0, 2);
        add(1, 1, 1, 1,   1, 1, 0, 1, 2);   // req on the boundary cycle

        #12;
        check("reset_main", 0, snap_m(), 6'b000000);
        check("reset_clamp", 0, snap_c(), 6'b000000);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            ifm.run = vq[i].run;
            ifm.sel = vq[i].sel;
            ifm.req = vq[i].req;
            @(posedge clk);
            #1;
            check("vec", i, snap_m(), vq[i].exp);
        end

        // Asynchronous reset while a switch is pending.
        ifm.req = 1'b0;
        ifm.run = 1'b0;
        #2 reset_n = 1'b0;
        #1 check("async_reset", 0, snap_m(), 6'b000000);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check("post_reset", i, snap_m(), 6'b000000);
        end

        // Preset of 1 is clamped to a 2-cycle period.
        cexp = '{6'b100000, 6'b000000, 6'b110000, 6'b000000, 6'b110000, 6'b000000};
        ifc.run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("clamp", i, snap_c(), cexp[i]);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
